// File: rtl/dlx_pkg.sv
// Shared DLX front-end definitions: fetch FSM states, the fetch payload
// (instruction word plus its address), the NOP word and the default reset PC.
package dlx_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  // Clear the byte offset so an address always names a whole word.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding buffer for a fetched word that arrived while decode was
// stalled.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   load, word_in : capture a word (data + pc) and mark the entry valid
//   clear         : drop the entry once it has moved into IF/ID
//   word_out      : buffered word
//   valid         : entry holds a live word
module fetch_hold_buf
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t word_in,
  output fetch_word_t word_out,
  output logic        valid
);

  // Load wins over clear; the two are never requested together.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_out <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      word_out <= word_in;
      valid    <= 1'b1;
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction memory, feeds the IF/ID
// register and handles stalls and branch redirects.
// Optional feature: BRANCH_DELAY_SLOT_EN -- when defined, the instruction
// sequentially following a taken branch is delivered; otherwise it is
// squashed and a one-cycle bubble is issued.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   imem_req, imem_addr         : fetch request and word-aligned address
//   imem_ack, imem_rdata        : memory response (zero-wait allowed)
//   stall                       : decode cannot accept a new instruction
//   branch_taken, branch_target : redirect request and address
//   instr, pc_out, instr_valid  : IF/ID register
module instr_fetch
  import dlx_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_q, pc_next, pc_inc;
  logic            pend_q, pend_set, pend_clear;
  logic [XLEN-1:0] pend_target_q, redir_target;
  logic            br_now, redir;
  logic            if_load, if_bubble;
  logic            buf_load, buf_clear, buf_valid;
  fetch_word_t     fetch_word, buf_word, if_word;

  // A redirect is live when a branch arrives unstalled, or one arrived
  // earlier while its following fetch was still outstanding.
  assign br_now       = branch_taken && !stall;
  assign redir        = br_now || pend_q;
  assign redir_target = br_now ? word_align(branch_target) : pend_target_q;
  assign pc_inc       = pc_q + INSTR_BYTES;
  assign fetch_word   = '{data: imem_rdata, pc: pc_q};
  assign imem_addr    = word_align(pc_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (imem_ack && stall) state_next = ST_HOLD;
      ST_HOLD:  if (!stall) state_next = ST_FETCH;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath control decode.
  always_comb begin
    pc_next    = pc_q;
    if_load    = 1'b0;
    if_bubble  = 1'b0;
    if_word    = fetch_word;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    pend_set   = 1'b0;
    pend_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (br_now) pc_next = redir_target;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (stall) begin
            buf_load = 1'b1;
            pc_next  = pc_inc;
          end else if (redir) begin
            // The arriving word is the one following the branch.
            pc_next    = redir_target;
            pend_clear = 1'b1;
            if_load    = DELAY_SLOT;
            if_bubble  = !DELAY_SLOT;
          end else begin
            if_load = 1'b1;
            pc_next = pc_inc;
          end
        end else if (!stall) begin
          // Decode consumed the previous word and nothing new arrived.
          if_bubble = 1'b1;
          if (br_now) pend_set = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          if_word   = buf_word;
          buf_clear = 1'b1;
          if (redir) begin
            pc_next    = redir_target;
            pend_clear = 1'b1;
            if_load    = DELAY_SLOT && buf_valid;
            if_bubble  = !DELAY_SLOT;
          end else begin
            if_load = buf_valid;
          end
        end
      end
      default: ;
    endcase
  end

  // PC, request, IF/ID register and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      imem_req      <= 1'b0;
      instr         <= NOP_INSTR;
      pc_out        <= RESET_PC;
      instr_valid   <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q     <= pc_next;
      imem_req <= (state_next == ST_FETCH);
      if (if_load) begin
        instr       <= if_word.data;
        pc_out      <= if_word.pc;
        instr_valid <= 1'b1;
      end else if (if_bubble) begin
        instr_valid <= 1'b0;
      end
      if (pend_set) begin
        pend_q        <= 1'b1;
        pend_target_q <= redir_target;
      end else if (pend_clear) begin
        pend_q        <= 1'b0;
      end
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .clear    (buf_clear),
    .word_in  (fetch_word),
    .word_out (buf_word),
    .valid    (buf_valid)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by randomized traffic,
// all checked against an in-order delivery scoreboard.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, stall, branch_taken, instr_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, instr, pc_out, key;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc_out;

  always #5 clk = ~clk;

  // Memory contents: each word is its own address xor a per-phase key.
  assign imem_rdata = imem_addr ^ key;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  instr_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(w_addr),
    .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .instr(w_instr), .pc_out(w_pc_out), .instr_valid(w_valid)
  );

  int          n_checks, n_pass, n_deliv;
  logic [31:0] exp_next, ds_tgt, l_instr, l_pc_out, l_addr;
  logic        ds_left, holding, br_open, l_req, l_valid, ack_auto;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: every delivered word must be the next expected address in
  // program order; a taken branch reroutes the order after its slot word.
  task automatic monitor();
    logic done_word;
    if (reset) begin
      check("rst_valid", 32'(instr_valid), 0);
      check("rst_req", 32'(imem_req), 0);
      check("rst_instr", instr, 0);
      check("rst_pc_out", pc_out, RST_PC);
      exp_next = RST_PC; ds_left = 1'b0; holding = 1'b0; br_open = 1'b0;
    end else begin
      done_word = (l_req && imem_ack && !stall) || (holding && !stall);
      check("addr_align", 32'(imem_addr[1:0]), 0);
      if (l_req && !imem_ack) begin
        check("addr_stable", imem_addr, l_addr);
        check("req_stable", 32'(imem_req), 1);
      end
      if (branch_taken && !stall) begin
        br_open = 1'b1;
        if (DS) begin
          ds_left = 1'b1;
          ds_tgt  = branch_target & 32'hFFFF_FFFC;
        end else begin
          exp_next = branch_target & 32'hFFFF_FFFC;
        end
      end
      if (stall) begin
        check("stall_instr", instr, l_instr);
        check("stall_pc_out", pc_out, l_pc_out);
        check("stall_valid", 32'(instr_valid), 32'(l_valid));
      end else if (instr_valid) begin
        n_deliv++;
        check("sb_pc", pc_out, exp_next);
        check("sb_instr", instr, exp_next ^ key);
        if (ds_left) begin
          ds_left  = 1'b0;
          exp_next = ds_tgt;
        end else begin
          exp_next = exp_next + 32'd4;
        end
      end
      if (done_word) br_open = 1'b0;
      if (l_req && imem_ack && stall) holding = 1'b1;
      else if (holding && !stall) holding = 1'b0;
      if (holding) check("hold_req_low", 32'(imem_req), 0);
    end
    l_req = imem_req; l_addr = imem_addr; l_instr = instr;
    l_pc_out = pc_out; l_valid = instr_valid;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    monitor();
    if (ack_auto) imem_ack = imem_req;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    repeat (n) cycle();
    check("rst_addr", imem_addr, RST_PC);
    reset = 1'b0;
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      found = instr_valid && (pc_out == pc);
    end
    check("reach_pc", 32'(found), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; n_deliv = 0; key = '0;
    reset = 1'b1; stall = 1'b0; imem_ack = 1'b0;
    branch_taken = 1'b0; branch_target = '0; ack_auto = 1'b1;
    l_req = 1'b0; l_valid = 1'b0; l_addr = '0; l_instr = '0; l_pc_out = '0;
    exp_next = RST_PC; ds_tgt = '0; ds_left = 1'b0; holding = 1'b0; br_open = 1'b0;

    // Streaming with ack tied to req.
    do_reset(3);
    cycle();
    check("boot_valid", 32'(instr_valid), 0);
    check("boot_req", 32'(imem_req), 1);
    check("boot_addr", imem_addr, RST_PC);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("stream_pc", pc_out, 32'(4 * k));
      check("stream_valid", 32'(instr_valid), 1);
    end

    // Three wait states on the fetch of 0x4.
    do_reset(2);
    cycle(); cycle();
    check("ws_first", pc_out, 32'h0);
    ack_auto = 1'b0; imem_ack = 1'b0;
    repeat (3) begin
      cycle();
      check("ws_addr", imem_addr, 32'h4);
      check("ws_req", 32'(imem_req), 1);
    end
    imem_ack = 1'b1; ack_auto = 1'b1;
    cycle();
    check("ws_deliver", pc_out, 32'h4);
    check("ws_valid", 32'(instr_valid), 1);
    cycle();
    check("ws_next", pc_out, 32'h8);

    // Stall spanning the ack of 0xC.
    do_reset(2);
    wait_pc(32'h8, 10);
    stall = 1'b1;
    repeat (4) begin
      cycle();
      check("st_pc_out", pc_out, 32'h8);
      check("st_instr", instr, 32'h8);
      check("st_req", 32'(imem_req), 0);
    end
    stall = 1'b0;
    cycle();
    check("st_release", pc_out, 32'hC);
    check("st_release_valid", 32'(instr_valid), 1);
    cycle();
    check("st_resume", pc_out, 32'h10);

    // Redirect while pc_out = 0x10, unaligned target.
    branch_taken = 1'b1; branch_target = 32'h103;
    cycle();
    branch_taken = 1'b0;
    check("br_addr", imem_addr, 32'h100);
    check("br_slot_valid", 32'(instr_valid), 32'(DS));
    check("br_slot_pc", pc_out, DS ? 32'h14 : 32'h10);
    cycle();
    check("br_target_pc", pc_out, 32'h100);
    check("br_target_valid", 32'(instr_valid), 1);
    check("br_target_instr", instr, 32'h100);

    // Reset while a fetch is outstanding, ack arriving during reset.
    ack_auto = 1'b0; imem_ack = 1'b0;
    cycle();
    check("mf_pending", 32'(imem_req), 1);
    reset = 1'b1; imem_ack = 1'b1;
    cycle();
    check("mf_addr", imem_addr, RST_PC);
    cycle();
    reset = 1'b0; imem_ack = 1'b0; ack_auto = 1'b1;
    cycle();
    check("mf_refetch_addr", imem_addr, RST_PC);
    check("mf_refetch_req", 32'(imem_req), 1);
    cycle();
    check("mf_first_pc", pc_out, RST_PC);
    check("mf_first_valid", 32'(instr_valid), 1);

    // PC wrap from 0xFFFF_FFFC.
    do_reset(2);
    cycle();
    check("wrap_addr0", w_addr, WRAP_PC);
    cycle();
    check("wrap_pc_out", w_pc_out, WRAP_PC);
    check("wrap_addr1", w_addr, 32'h0);
    check("wrap_valid", 32'(w_valid), 1);
    cycle();
    check("wrap_next_pc", w_pc_out, 32'h0);
    check("wrap_next_instr", w_instr, 32'h0);
    check("wrap_req", 32'(w_req), 1);

    // Randomized traffic: wait states, stalls, redirects, occasional reset.
    ack_auto = 1'b0;
    key = $urandom;
    do_reset(2);
    n_deliv = 0;
    for (int c = 0; c < 4000; c++) begin
      reset         = ($urandom_range(0, 299) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      imem_ack      = reset ? 1'($urandom) : (imem_req && ($urandom_range(0, 2) != 0));
      branch_taken  = !reset && !stall && (imem_req || holding) && !br_open &&
                      ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      cycle();
    end
    check("rand_progress", 32'(n_deliv > 500), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
